// File: rtl/sdram_device_model.sv
`default_nettype none
// ============================================================================
// Module      : sdram_device_model
// Description : Synthesizable SDRAM device responder with bank/timing checks,
//               small backing store and CAS-latency read return.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_device_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3,
    parameter int T_RFC    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cle,
    input  logic        sdram_cs,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic        sdram_dqm,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic [31:0] ctrl_dq_in,
    output logic [31:0] ctrl_dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic        proto_err,
    output logic [2:0]  err_code,
    output logic [15:0] ref_cnt
);

    localparam int         c_ADDR_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int         c_DEPTH     = 1 << c_ADDR_BITS;
    localparam logic [7:0] c_RCD_INIT  = 8'(T_RCD - 1);
    localparam logic [7:0] c_RP_INIT   = 8'(T_RP - 1);
    localparam logic [7:0] c_RFC_INIT  = 8'(T_RFC - 1);

    localparam logic [3:0] c_CMD_ACT = 4'b0011;
    localparam logic [3:0] c_CMD_RD  = 4'b0101;
    localparam logic [3:0] c_CMD_WR  = 4'b0100;
    localparam logic [3:0] c_CMD_PRE = 4'b0010;
    localparam logic [3:0] c_CMD_REF = 4'b0001;
    localparam logic [3:0] c_CMD_LMR = 4'b0000;
    localparam logic [3:0] c_CMD_NOP = 4'b0111;

    typedef struct packed {
        logic                   valid;
        logic [c_ADDR_BITS-1:0] addr;
    } beat_t;

    logic [31:0]         r_mem [c_DEPTH];
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    logic [7:0]          r_rcd [4];
    logic [7:0]          r_rp  [4];
    logic [7:0]          r_rfc;
    logic [1:0]          r_cl;
    beat_t               r_pipe [4];

    logic [3:0]             w_cmd;
    logic                   w_is_cmd;
    logic                   w_act, w_rd, w_wr, w_pre, w_ref, w_lmr;
    logic                   w_bank_open;
    logic                   w_rd_ok, w_wr_ok;
    logic [c_ADDR_BITS-1:0] w_addr;
    logic [1:0]             w_cl_next;
    logic [2:0]             w_err_code;
    logic                   w_unused_a;

    assign w_unused_a  = ^sdram_a;
    assign w_cmd       = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    // Any decoded command other than NOP/deselect, including TERM.
    assign w_is_cmd    = sdram_cle && !sdram_cs && (w_cmd != c_CMD_NOP);
    assign w_act       = sdram_cle && (w_cmd == c_CMD_ACT);
    assign w_rd        = sdram_cle && (w_cmd == c_CMD_RD);
    assign w_wr        = sdram_cle && (w_cmd == c_CMD_WR);
    assign w_pre       = sdram_cle && (w_cmd == c_CMD_PRE);
    assign w_ref       = sdram_cle && (w_cmd == c_CMD_REF);
    assign w_lmr       = sdram_cle && (w_cmd == c_CMD_LMR);
    assign w_bank_open = r_open[sdram_ba];
    assign w_rd_ok     = w_rd && w_bank_open;
    assign w_wr_ok     = w_wr && w_bank_open;
    assign w_addr      = {sdram_ba, r_row[sdram_ba], sdram_a[COL_BITS-1:0]};
    assign w_cl_next   = (sdram_a[6:4] == 3'd2) ? 2'd2 : 2'd3;

    // Evaluated highest code first so the lowest applicable code wins.
    always_comb begin
        w_err_code = 3'd0;
        if (w_is_cmd && !init_done && !w_lmr)       w_err_code = 3'd7;
        if (w_ref && (|r_open))                     w_err_code = 3'd6;
        if (w_is_cmd && (r_rfc != '0))              w_err_code = 3'd5;
        if (w_act && (r_rp[sdram_ba] != '0))        w_err_code = 3'd4;
        if ((w_rd || w_wr) && (r_rcd[sdram_ba] != '0)) w_err_code = 3'd3;
        if (w_act && w_bank_open)                   w_err_code = 3'd2;
        if ((w_rd || w_wr) && !w_bank_open)         w_err_code = 3'd1;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !sdram_dqm) begin
            r_mem[w_addr] <= ctrl_dq_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open      <= '0;
            r_rfc       <= '0;
            r_cl        <= 2'd2;
            dq_oe       <= 1'b0;
            ctrl_dq_out <= '0;
            init_done   <= 1'b0;
            proto_err   <= 1'b0;
            err_code    <= '0;
            ref_cnt     <= '0;
            for (int b = 0; b < 4; b++) begin
                r_row[b]  <= '0;
                r_rcd[b]  <= '0;
                r_rp[b]   <= '0;
                r_pipe[b] <= '0;
            end
        end else begin
            // Read return pipe shifts unconditionally; a READ lands in the
            // slot that reaches the output register CL+1 edges later.
            for (int i = 0; i < 3; i++) begin
                r_pipe[i] <= r_pipe[i+1];
            end
            r_pipe[3] <= '0;
            if (w_rd_ok) begin
                r_pipe[r_cl] <= '{valid: !sdram_dqm, addr: w_addr};
            end
            dq_oe       <= r_pipe[0].valid;
            ctrl_dq_out <= r_pipe[0].valid ? r_mem[r_pipe[0].addr] : '0;

            for (int b = 0; b < 4; b++) begin
                if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - 8'd1;
                if (r_rp[b]  != '0) r_rp[b]  <= r_rp[b]  - 8'd1;
            end
            if (r_rfc != '0) r_rfc <= r_rfc - 8'd1;

            if (w_act) begin
                r_open[sdram_ba] <= 1'b1;
                r_row[sdram_ba]  <= sdram_a[ROW_BITS-1:0];
                r_rcd[sdram_ba]  <= c_RCD_INIT;
            end
            if (w_pre) begin
                for (int b = 0; b < 4; b++) begin
                    if (sdram_a[10] || (sdram_ba == 2'(b))) begin
                        r_open[b] <= 1'b0;
                        r_rp[b]   <= c_RP_INIT;
                    end
                end
            end
            if (w_ref) begin
                ref_cnt <= ref_cnt + 16'd1;
                r_rfc   <= c_RFC_INIT;
            end
            if (w_lmr) begin
                r_cl      <= w_cl_next;
                init_done <= 1'b1;
            end
            if (!proto_err && (w_err_code != 3'd0)) begin
                proto_err <= 1'b1;
                err_code  <= w_err_code;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_device_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_device_model
// Description : Directed bench for sdram_device_model with read-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_device_model;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [31:0] ctrl_dq_in;
    logic [31:0] ctrl_dq_out;
    logic        dq_oe, init_done, proto_err;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   tb_cl  = 2;
    int   n_cmp  = 0;
    int   n_err  = 0;

    sdram_device_model dut (
        .clk        (clk),
        .rst        (rst),
        .sdram_cle  (sdram_cle),
        .sdram_cs   (sdram_cs),
        .sdram_ras  (sdram_ras),
        .sdram_cas  (sdram_cas),
        .sdram_we   (sdram_we),
        .sdram_dqm  (sdram_dqm),
        .sdram_ba   (sdram_ba),
        .sdram_a    (sdram_a),
        .ctrl_dq_in (ctrl_dq_in),
        .ctrl_dq_out(ctrl_dq_out),
        .dq_oe      (dq_oe),
        .init_done  (init_done),
        .proto_err  (proto_err),
        .err_code   (err_code),
        .ref_cnt    (ref_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor: dq_oe must be high exactly on the cycles the scoreboard expects.
    always @(negedge clk) begin
        logic exp_oe;
        exp_t e;
        exp_oe = (sb.size() > 0) && (sb[0].due == cyc);
        n_cmp++;
        assert (dq_oe === exp_oe) else begin
            n_err++;
            $error("FAIL dq_oe cyc=%0d got %b expected %b", cyc, dq_oe, exp_oe);
        end
        if (exp_oe) begin
            e = sb.pop_front();
            n_cmp++;
            assert (ctrl_dq_out === e.data) else begin
                n_err++;
                $error("FAIL rd_data cyc=%0d got %h expected %h", cyc, ctrl_dq_out, e.data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_nop();
        sdram_cle = 1'b1;
        {sdram_cs, sdram_ras, sdram_cas, sdram_we} = 4'b1111;
        sdram_dqm  = 1'b0;
        sdram_ba   = '0;
        sdram_a    = '0;
        ctrl_dq_in = '0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_nop();
        end
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [31:0] d, input logic dqm);
        @(negedge clk);
        sdram_cle = 1'b1;
        {sdram_cs, sdram_ras, sdram_cas, sdram_we} = c;
        sdram_ba   = ba;
        sdram_a    = a;
        ctrl_dq_in = d;
        sdram_dqm  = dqm;
    endtask

    task automatic rd(input logic [1:0] ba, input logic [5:0] col, input logic dqm,
                      input logic beat, input logic [31:0] exp);
        cmd(C_RD, ba, {7'd0, col}, 32'd0, dqm);
        if (beat) sb.push_back('{due: cyc + tb_cl + 2, data: exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_nop();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tb_cl = 2;
    endtask

    initial begin
        rst = 1'b1;
        drive_nop();
        repeat (2) @(negedge clk);
        chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("rst_dq_out", ctrl_dq_out, 32'd0);
        chk("rst_init", {31'd0, init_done}, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        chk("rst_ecode", {29'd0, err_code}, 32'd0);
        chk("rst_refcnt", {16'd0, ref_cnt}, 32'd0);
        rst = 1'b0;

        // Init, open bank 1 row 5, write then read back.
        cmd(C_LMR, 2'd0, 13'h022, 32'd0, 1'b0);
        nop(1);
        chk("init_done", {31'd0, init_done}, 32'd1);
        cmd(C_ACT, 2'd1, 13'd5, 32'd0, 1'b0);
        nop(2);
        cmd(C_WR, 2'd1, 13'd4, 32'hDEADBEEF, 1'b0);
        rd(2'd1, 6'd4, 1'b0, 1'b1, 32'hDEADBEEF);
        nop(6);
        chk("wr_rd_perr", {31'd0, proto_err}, 32'd0);

        // Back-to-back reads.
        cmd(C_WR, 2'd1, 13'd0, 32'd1, 1'b0);
        cmd(C_WR, 2'd1, 13'd1, 32'd2, 1'b0);
        cmd(C_WR, 2'd1, 13'd2, 32'd3, 1'b0);
        rd(2'd1, 6'd0, 1'b0, 1'b1, 32'd1);
        rd(2'd1, 6'd1, 1'b0, 1'b1, 32'd2);
        rd(2'd1, 6'd2, 1'b0, 1'b1, 32'd3);
        nop(6);

        // Data mask on write and read.
        cmd(C_WR, 2'd1, 13'd8, 32'h12345678, 1'b0);
        cmd(C_WR, 2'd1, 13'd8, 32'hAAAA5555, 1'b1);
        rd(2'd1, 6'd8, 1'b0, 1'b1, 32'h12345678);
        rd(2'd1, 6'd8, 1'b1, 1'b0, 32'd0);
        nop(6);
        chk("dqm_perr", {31'd0, proto_err}, 32'd0);

        // Read to closed bank, then a later violation must not override.
        rd(2'd2, 6'd0, 1'b0, 1'b0, 32'd0);
        nop(1);
        chk("closed_perr", {31'd0, proto_err}, 32'd1);
        chk("closed_code", {29'd0, err_code}, 32'd1);
        cmd(C_ACT, 2'd1, 13'd5, 32'd0, 1'b0);
        nop(6);
        chk("sticky_code", {29'd0, err_code}, 32'd1);

        // tRCD violation still returns data; memory survives reset.
        do_reset();
        chk("rst2_perr", {31'd0, proto_err}, 32'd0);
        cmd(C_LMR, 2'd0, 13'h022, 32'd0, 1'b0);
        cmd(C_ACT, 2'd1, 13'd5, 32'd0, 1'b0);
        rd(2'd1, 6'd4, 1'b0, 1'b1, 32'hDEADBEEF);
        nop(6);
        chk("rcd_code", {29'd0, err_code}, 32'd3);

        // REF followed too soon by ACT.
        do_reset();
        cmd(C_LMR, 2'd0, 13'h022, 32'd0, 1'b0);
        cmd(C_PRE, 2'd0, 13'h400, 32'd0, 1'b0);
        cmd(C_REF, 2'd0, 13'd0, 32'd0, 1'b0);
        nop(1);
        cmd(C_ACT, 2'd0, 13'd1, 32'd0, 1'b0);
        nop(1);
        chk("rfc_code", {29'd0, err_code}, 32'd5);
        chk("rfc_refcnt", {16'd0, ref_cnt}, 32'd1);

        do_reset();
        chk("rst3_perr", {31'd0, proto_err}, 32'd0);
        chk("rst3_refcnt", {16'd0, ref_cnt}, 32'd0);

        // REF before init, then wrap of the refresh counter.
        cmd(C_REF, 2'd0, 13'd0, 32'd0, 1'b0);
        nop(1);
        chk("preinit_code", {29'd0, err_code}, 32'd7);
        for (int i = 1; i < 70000; i++) begin
            cmd(C_REF, 2'd0, 13'd0, 32'd0, 1'b0);
        end
        nop(1);
        chk("ref_wrap", {16'd0, ref_cnt}, 32'd4464);

        nop(8);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
